tmr_voter_mgr: RTL and testbench
================================

TMR_VOTER_MGR -- requirements
Module: tmr_voter_mgr

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning voted data width (1..512).
REQ-002 The block SHALL have parameter THRESH, default 4, meaning consecutive mismatching valid samples before a lane is failed (1..255).
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning width of each saturating error counter.
REQ-004 The block SHALL have port clk, input, 1, the clock.
REQ-005 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1, meaning lanes A/B/C carry a sample this cycle.
REQ-007 The block SHALL have ports in_a, in_b and in_c, input, WIDTH each, meaning redundant lane data.
REQ-008 The block SHALL have port resync_ack, input, 1, meaning the system has re-synchronised the failed cores.
REQ-009 The block SHALL have port voted_out, output, WIDTH, meaning the voted data.
REQ-010 The block SHALL have port out_valid, output, 1, meaning voted_out and the flags are valid.
REQ-011 The block SHALL have port disagreement, output, 1, meaning any two healthy lanes differ.
REQ-012 The block SHALL have port fault_flags, output, 3, meaning [2]=A, [1]=B, [0]=C differs from the vote.
REQ-013 The block SHALL have port lane_failed, output, 3, meaning the lane is excluded from voting (bit order as fault_flags).
REQ-014 The block SHALL have ports err_cnt_a, err_cnt_b and err_cnt_c, output, CNT_W each, meaning lifetime mismatch counts.
REQ-015 The block SHALL have port resync_req, output, 1, meaning a resync is requested.
REQ-016 The block SHALL have port uncorrectable, output, 1, meaning the output is not backed by a majority.

Function
REQ-017 All outputs SHALL be registered, with exactly 1-cycle latency from in_valid to out_valid.
REQ-018 With 3 healthy lanes, voted_out SHALL be the bitwise 2-of-3 majority.
REQ-019 With 2 healthy lanes, voted_out SHALL be the lower-lettered healthy lane (A>B>C), and uncorrectable SHALL be 1 when those two lanes differ.
REQ-020 With 1 healthy lane, voted_out SHALL be that lane, and uncorrectable SHALL be 1 on every valid output.
REQ-021 With 0 healthy lanes, voted_out SHALL be in_a, and uncorrectable SHALL be 1 on every valid output.
REQ-022 fault_flags[x] SHALL be 1 only if lane x is healthy and differs from the vote; failed lanes SHALL report 0.
REQ-023 disagreement SHALL consider healthy lanes only, and SHALL be 0 with fewer than 2 healthy lanes.
REQ-024 Each lane SHALL have a consecutive-mismatch counter, incremented on a valid sample where that lane's fault flag is 1 and cleared on a valid sample where it is 0.
REQ-025 Each lane SHALL be in one of two states: HEALTHY or FAILED.
REQ-026 A lane SHALL transition HEALTHY->FAILED when its consecutive-mismatch counter reaches THRESH, and lane_failed SHALL update in the same cycle that sample's outputs appear.
REQ-027 Multiple lanes reaching THRESH on the same sample SHALL all fail simultaneously.
REQ-028 err_cnt_x SHALL increment by 1 per valid sample with fault_flags[x]=1, and SHALL saturate at 2^CNT_W-1.
REQ-029 err_cnt_x SHALL never be cleared except by reset, including on resync.
REQ-030 When in_valid=0, voted_out SHALL hold its value, fault_flags, disagreement and uncorrectable SHALL be 0, and all counters and states SHALL be unchanged.
REQ-031 resync_req SHALL rise the cycle after any lane is FAILED, and SHALL stay high until resync_ack is sampled high.
REQ-032 On resync_ack while resync_req=1, every FAILED lane SHALL transition FAILED->HEALTHY with its consecutive counter cleared, and resync_req SHALL fall on the next cycle.
REQ-033 resync_ack while resync_req=0 SHALL be ignored.
REQ-034 If resync_ack coincides with a lane reaching THRESH, that lane SHALL end FAILED, and resync_req SHALL remain 1.

Reset
REQ-035 On rst_n=0, all outputs, counters and lane states SHALL clear asynchronously: voted_out=0, out_valid=0, flags=0, lane_failed=000, err_cnt=0, resync_req=0, uncorrectable=0, all lanes HEALTHY.
REQ-036 Reset deassertion SHALL be used synchronously, with the first sample accepted on the first clk edge with rst_n=1.

Verification (WIDTH=8, THRESH=3)
REQ-037 The bench SHALL drive a=b=c=0xA5, valid=1 -> next cycle voted_out=0xA5, out_valid=1, disagreement=0, fault_flags=000.
REQ-038 The bench SHALL drive a=0xFF, b=c=0x0F -> voted_out=0x0F, fault_flags=100, disagreement=1, err_cnt_a=1.
REQ-039 The bench SHALL drive A wrong on 3 consecutive valid samples -> lane_failed=100 with the 3rd output, resync_req=1 next cycle; then a=0x00, b=c=0x3C -> voted_out=0x3C, fault_flags=000, disagreement=0.
REQ-040 With A failed, the bench SHALL drive b=0x11, c=0x22 -> voted_out=0x11, uncorrectable=1, fault_flags=001.
REQ-041 The bench SHALL pulse resync_ack -> lane_failed=000, resync_req=0 next cycle, err_cnt_a unchanged at 3.
REQ-042 The bench SHALL assert rst_n=0 mid-stream with lane B failed -> all outputs 0 immediately, without a clk edge.

Source files
------------

// File: rtl/tmr_voter_mgr.sv
// rtl/tmr_voter_mgr.sv - triple-modular-redundancy voter with lane health tracking and resync handshake
//
// Votes three redundant lanes into one output. Lanes that disagree with the
// vote on THRESH consecutive valid samples are marked failed and dropped from
// voting until the system acknowledges a resync of the failed cores.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid            lanes carry a sample this cycle
//   in_a/in_b/in_c      redundant lane data (WIDTH)
//   resync_ack          failed cores have been re-synchronised
//   voted_out           voted data (holds when no sample)
//   out_valid           voted_out and per-sample flags are valid
//   disagreement        two healthy lanes differ
//   fault_flags         [2]=A [1]=B [0]=C healthy and differs from vote
//   lane_failed         lane excluded from voting (same bit order)
//   err_cnt_a/b/c       saturating lifetime mismatch counters (CNT_W)
//   resync_req          resync requested
//   uncorrectable       output not backed by two agreeing healthy lanes

module tmr_voter_mgr #(
    parameter int WIDTH  = 32,
    parameter int THRESH = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic             resync_ack,
    output logic [WIDTH-1:0] voted_out,
    output logic             out_valid,
    output logic             disagreement,
    output logic [2:0]       fault_flags,
    output logic [2:0]       lane_failed,
    output logic [CNT_W-1:0] err_cnt_a,
    output logic [CNT_W-1:0] err_cnt_b,
    output logic [CNT_W-1:0] err_cnt_c,
    output logic             resync_req,
    output logic             uncorrectable
);

    localparam logic [7:0]       TH    = 8'(THRESH);
    localparam logic [CNT_W-1:0] ONE_E = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]      r_voted;
    logic                  r_out_valid;
    logic                  r_dis;
    logic [2:0]            r_flags;
    logic [2:0]            r_failed;
    logic                  r_req;
    logic                  r_unc;
    logic [2:0][7:0]       r_consec;
    logic [2:0][CNT_W-1:0] r_err;

    logic [2:0]            w_healthy;
    logic [WIDTH-1:0]      w_vote;
    logic [2:0]            w_eq;
    logic [2:0]            w_flags;
    logic [2:0]            w_match;
    logic [1:0]            w_nmatch;
    logic                  w_unc;
    logic                  w_dis;
    logic [2:0]            w_fail_now;
    logic                  w_ack;

    assign w_healthy = ~r_failed;
    assign w_ack     = resync_ack & r_req;

    always_comb begin
        w_vote = in_a;
        // Full majority only with all three lanes; otherwise the first healthy
        // lane in A, B, C order wins, falling back to A when none remain.
        if (&w_healthy)
            w_vote = (in_a & in_b) | (in_a & in_c) | (in_b & in_c);
        else if (w_healthy[2])
            w_vote = in_a;
        else if (w_healthy[1])
            w_vote = in_b;
        else if (w_healthy[0])
            w_vote = in_c;
        else
            w_vote = in_a;
    end

    assign w_eq     = {in_a == w_vote, in_b == w_vote, in_c == w_vote};
    assign w_flags  = w_healthy & ~w_eq;
    assign w_match  = w_healthy & w_eq;
    assign w_nmatch = 2'(w_match[2]) + 2'(w_match[1]) + 2'(w_match[0]);
    // The output is trusted only if at least two healthy lanes carry it.
    assign w_unc    = (w_nmatch < 2'd2);
    assign w_dis    = (w_healthy[2] & w_healthy[1] & (in_a != in_b)) |
                      (w_healthy[2] & w_healthy[0] & (in_a != in_c)) |
                      (w_healthy[1] & w_healthy[0] & (in_b != in_c));

    // A healthy lane's consecutive count stays below THRESH, so +1 cannot wrap.
    always_comb begin
        for (int i = 0; i < 3; i++)
            w_fail_now[i] = in_valid & w_flags[i] & ((r_consec[i] + 8'd1) == TH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_voted     <= '0;
            r_out_valid <= 1'b0;
            r_dis       <= 1'b0;
            r_flags     <= 3'b000;
            r_failed    <= 3'b000;
            r_req       <= 1'b0;
            r_unc       <= 1'b0;
            r_consec    <= '0;
            r_err       <= '0;
        end else begin
            if (in_valid) begin
                r_voted     <= w_vote;
                r_out_valid <= 1'b1;
                r_dis       <= w_dis;
                r_flags     <= w_flags;
                r_unc       <= w_unc;
                for (int i = 0; i < 3; i++) begin
                    r_consec[i] <= w_flags[i] ? (r_consec[i] + 8'd1) : 8'd0;
                    if (w_flags[i] && !(&r_err[i]))
                        r_err[i] <= r_err[i] + ONE_E;
                end
            end else begin
                r_out_valid <= 1'b0;
                r_dis       <= 1'b0;
                r_flags     <= 3'b000;
                r_unc       <= 1'b0;
            end

            // Acked lanes come back clean; failed lanes never carry a flag,
            // so this cannot collide with a lane failing on the same sample.
            if (w_ack) begin
                for (int i = 0; i < 3; i++)
                    if (r_failed[i])
                        r_consec[i] <= 8'd0;
            end

            r_failed <= (r_failed & ~{3{w_ack}}) | w_fail_now;

            // A lane failing on the very sample that is acked keeps the
            // request alive; otherwise the ack drops it.
            if (w_ack)
                r_req <= |w_fail_now;
            else
                r_req <= r_req | (|r_failed);
        end
    end

    assign voted_out     = r_voted;
    assign out_valid     = r_out_valid;
    assign disagreement  = r_dis;
    assign fault_flags   = r_flags;
    assign lane_failed   = r_failed;
    assign err_cnt_a     = r_err[2];
    assign err_cnt_b     = r_err[1];
    assign err_cnt_c     = r_err[0];
    assign resync_req    = r_req;
    assign uncorrectable = r_unc;

endmodule

// File: tb/tb_tmr_voter_mgr.sv
// tb/tb_tmr_voter_mgr.sv - scoreboard bench for tmr_voter_mgr (WIDTH=8, THRESH=3, CNT_W=4)

module tb_tmr_voter_mgr;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_a = '0, in_b = '0, in_c = '0;
    logic       resync_ack = 1'b0;
    logic [7:0] voted_out;
    logic       out_valid, disagreement, resync_req, uncorrectable;
    logic [2:0] fault_flags, lane_failed;
    logic [3:0] err_cnt_a, err_cnt_b, err_cnt_c;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] v;
        logic [2:0] ff;
        logic       dis;
        logic       unc;
        logic [2:0] lf;
        logic [3:0] ea, eb, ec;
    } exp_t;

    exp_t q[$];

    tmr_voter_mgr #(.WIDTH(8), .THRESH(3), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .resync_ack(resync_ack),
        .voted_out(voted_out), .out_valid(out_valid), .disagreement(disagreement),
        .fault_flags(fault_flags), .lane_failed(lane_failed),
        .err_cnt_a(err_cnt_a), .err_cnt_b(err_cnt_b), .err_cnt_c(err_cnt_c),
        .resync_req(resync_req), .uncorrectable(uncorrectable)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] v, input logic [2:0] ff, input logic dis,
                                input logic unc, input logic [2:0] lf,
                                input logic [3:0] ea, input logic [3:0] eb, input logic [3:0] ec);
        exp_t e;
        e.v = v; e.ff = ff; e.dis = dis; e.unc = unc; e.lf = lf;
        e.ea = ea; e.eb = eb; e.ec = ec;
        return e;
    endfunction

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic ack, input exp_t e);
        q.push_back(e);
        in_a = a; in_b = b; in_c = c; in_valid = 1'b1; resync_ack = ack;
        @(posedge clk); #1;
        in_valid = 1'b0; resync_ack = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    // Monitor: every valid output is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("voted_out",     32'(voted_out),     32'(e.v));
                check("fault_flags",   32'(fault_flags),   32'(e.ff));
                check("disagreement",  32'(disagreement),  32'(e.dis));
                check("uncorrectable", 32'(uncorrectable), 32'(e.unc));
                check("lane_failed",   32'(lane_failed),   32'(e.lf));
                check("err_cnt_a",     32'(err_cnt_a),     32'(e.ea));
                check("err_cnt_b",     32'(err_cnt_b),     32'(e.eb));
                check("err_cnt_c",     32'(err_cnt_c),     32'(e.ec));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_voted",      32'(voted_out),   32'h0);
        check("rst_out_valid",  32'(out_valid),   32'h0);
        check("rst_lane_failed",32'(lane_failed), 32'h0);
        check("rst_resync_req", 32'(resync_req),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All lanes agree
        send(8'hA5, 8'hA5, 8'hA5, 1'b0, mk(8'hA5, 3'b000, 0, 0, 3'b000, 4'd0, 4'd0, 4'd0));
        // A outvoted
        send(8'hFF, 8'h0F, 8'h0F, 1'b0, mk(8'h0F, 3'b100, 1, 0, 3'b000, 4'd1, 4'd0, 4'd0));
        // Idle cycle: flags drop, vote holds, consecutive count kept
        idle();
        check("idle_out_valid", 32'(out_valid),    32'h0);
        check("idle_voted_hold",32'(voted_out),    32'h0F);
        check("idle_flags",     32'(fault_flags),  32'h0);
        check("idle_dis",       32'(disagreement), 32'h0);
        send(8'hFF, 8'h0F, 8'h0F, 1'b0, mk(8'h0F, 3'b100, 1, 0, 3'b000, 4'd2, 4'd0, 4'd0));
        // Third consecutive A mismatch fails A with this output
        send(8'hFF, 8'h0F, 8'h0F, 1'b0, mk(8'h0F, 3'b100, 1, 0, 3'b100, 4'd3, 4'd0, 4'd0));
        check("req_not_yet", 32'(resync_req), 32'h0);
        idle();
        check("req_rises", 32'(resync_req), 32'h1);

        // A excluded: B/C agree
        send(8'h00, 8'h3C, 8'h3C, 1'b0, mk(8'h3C, 3'b000, 0, 0, 3'b100, 4'd3, 4'd0, 4'd0));
        // A excluded: B/C differ, B wins, uncorrectable
        send(8'h00, 8'h11, 8'h22, 1'b0, mk(8'h11, 3'b001, 1, 1, 3'b100, 4'd3, 4'd0, 4'd1));

        // Resync acknowledgement
        resync_ack = 1'b1;
        @(posedge clk); #1;
        resync_ack = 1'b0;
        check("ack_lane_failed", 32'(lane_failed), 32'h0);
        check("ack_req_falls",   32'(resync_req),  32'h0);
        check("ack_err_a_kept",  32'(err_cnt_a),   32'd3);

        // B wrong twice then right, repeated: never fails, err_cnt_b saturates at 15
        for (int k = 0; k < 8; k++) begin
            send(8'h55, 8'hAA, 8'h55, 1'b0,
                 mk(8'h55, 3'b010, 1, 0, 3'b000, 4'd3, 4'((2*k+1 > 15) ? 15 : 2*k+1), 4'd1));
            send(8'h55, 8'hAA, 8'h55, 1'b0,
                 mk(8'h55, 3'b010, 1, 0, 3'b000, 4'd3, 4'((2*k+2 > 15) ? 15 : 2*k+2), 4'd1));
            send(8'h55, 8'h55, 8'h55, 1'b0,
                 mk(8'h55, 3'b000, 0, 0, 3'b000, 4'd3, 4'((2*k+2 > 15) ? 15 : 2*k+2), 4'd1));
        end

        // Fail C
        send(8'h55, 8'h55, 8'hAA, 1'b0, mk(8'h55, 3'b001, 1, 0, 3'b000, 4'd3, 4'd15, 4'd2));
        send(8'h55, 8'h55, 8'hAA, 1'b0, mk(8'h55, 3'b001, 1, 0, 3'b000, 4'd3, 4'd15, 4'd3));
        send(8'h55, 8'h55, 8'hAA, 1'b0, mk(8'h55, 3'b001, 1, 0, 3'b001, 4'd3, 4'd15, 4'd4));
        idle();
        check("req_c_failed", 32'(resync_req), 32'h1);

        // B reaches THRESH on the same sample as the ack: C recovers, B fails
        send(8'h55, 8'hAA, 8'h55, 1'b0, mk(8'h55, 3'b010, 1, 1, 3'b001, 4'd3, 4'd15, 4'd4));
        send(8'h55, 8'hAA, 8'h55, 1'b0, mk(8'h55, 3'b010, 1, 1, 3'b001, 4'd3, 4'd15, 4'd4));
        send(8'h55, 8'hAA, 8'h55, 1'b1, mk(8'h55, 3'b010, 1, 1, 3'b010, 4'd3, 4'd15, 4'd4));
        idle();
        check("coincide_req_kept", 32'(resync_req),  32'h1);
        check("coincide_lf",       32'(lane_failed), 32'h2);

        // Asynchronous reset mid-stream with B failed, checked before any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_voted",     32'(voted_out),   32'h0);
        check("arst_lf",        32'(lane_failed), 32'h0);
        check("arst_req",       32'(resync_req),  32'h0);
        check("arst_err_b",     32'(err_cnt_b),   32'h0);
        check("arst_err_a",     32'(err_cnt_a),   32'h0);
        check("arst_out_valid", 32'(out_valid),   32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // B healthy again after reset: full three-lane vote
        send(8'h12, 8'h34, 8'h12, 1'b0, mk(8'h12, 3'b010, 1, 0, 3'b000, 4'd0, 4'd1, 4'd0));

        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
